// File: rtl/approx_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_pkg
// Purpose  : Shared constants, stage payload type and the loss reference
//            function for the approximate pipelined multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package approx_mul_pkg;

    localparam int STAGES    = 3;
    localparam int MAX_WIDTH = 32;
    localparam int MAX_ROWS  = MAX_WIDTH / 2;

    // Sized for the widest legal operand; narrower instances leave upper bits zero.
    typedef struct packed {
        logic                                valid;
        logic                                mode;
        logic [MAX_ROWS-1:0][MAX_WIDTH-1:0]  t;
        logic [MAX_ROWS-1:0][MAX_WIDTH-2:0]  b;
        logic [MAX_ROWS-1:0]                 m;
    } stage_t;

    // Amount by which the approximate product falls short of x*y.
    function automatic logic [2*MAX_WIDTH-1:0] approx_loss(
        input logic [MAX_WIDTH-1:0] x,
        input logic [MAX_WIDTH-1:0] y,
        input logic                 approx_en,
        input int                   width,
        input int                   approx_cols
    );
        logic [2*MAX_WIDTH-1:0] loss;
        loss = '0;
        if (approx_en) begin
            for (int k = 0; k < width / 2; k++) begin
                for (int j = 1; j < width; j++) begin
                    if (((2 * k + j) < approx_cols) && y[j] && x[2*k] && y[j-1] && x[2*k+1])
                        loss = loss + ((2*MAX_WIDTH)'(1) << (2 * k + j));
                end
            end
        end
        return loss;
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_mul_ha_row.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_ha_row
// Purpose  : One pair-row of the partial-product array: half-adder cells,
//            or OR-only cells below APPROX_COLS when approximation is enabled.
// Revision : 1.0 - initial release
// ============================================================================
module approx_mul_ha_row
    import approx_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4,
    parameter int K           = 0
) (
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       x_pair,
    input  logic             approx_en,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-2:0] b
);

    // t[j] has weight 2K+j; b[j-1] is the carry of cell j, weight 2K+j+1.
    assign t[0] = y[0] & x_pair[0];

    for (genvar j = 1; j < WIDTH; j++) begin : g_cell
        logic w_pa;
        logic w_pb;
        assign w_pa = y[j]   & x_pair[0];
        assign w_pb = y[j-1] & x_pair[1];

        if ((2 * K + j) < APPROX_COLS) begin : g_or
            assign t[j]   = approx_en ? (w_pa | w_pb) : (w_pa ^ w_pb);
            assign b[j-1] = approx_en ? 1'b0 : (w_pa & w_pb);
        end else begin : g_ha
            assign t[j]   = w_pa ^ w_pb;
            assign b[j-1] = w_pa & w_pb;
        end
    end

endmodule
`default_nettype wire

// File: rtl/approx_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_pipe
// Purpose  : 3-stage valid/ready pipelined approximate unsigned multiplier.
//            Optional error statistics enabled by APPROX_MUL_ERR_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod
`ifdef APPROX_MUL_ERR_STAT_EN
    ,
    input  logic               stat_clr,
    output logic [15:0]        err_cnt,
    output logic [2*WIDTH-1:0] err_max
`endif
);

    localparam int ROWS = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;

    logic             w_stall;
    stage_t           w_s1_next;
    stage_t           r_s1;
    logic [WIDTH-1:0] w_t [ROWS];
    logic [WIDTH-2:0] w_b [ROWS];
    logic [PW-1:0]    w_sum_a;
    logic [PW-1:0]    w_sum_b;
    logic [PW-1:0]    w_prod_next;
    logic             r_v2;
    logic [PW-1:0]    r_a2;
    logic [PW-1:0]    r_b2;
    logic             r_v3;
    logic [PW-1:0]    r_prod;
    logic             w_unused_s1;

    assign w_stall   = r_v3 & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_v3;
    assign prod      = r_prod;

    for (genvar k = 0; k < ROWS; k++) begin : g_row
        approx_mul_ha_row #(
            .WIDTH       (WIDTH),
            .APPROX_COLS (APPROX_COLS),
            .K           (k)
        ) u_row (
            .y         (y),
            .x_pair    (x[2*k+1:2*k]),
            .approx_en (approx_en),
            .t         (w_t[k]),
            .b         (w_b[k])
        );
    end

    // m[k] is the lone top partial product y[MSB]&x[2k+1], weight 2k+WIDTH.
    always_comb begin
        w_s1_next       = '0;
        w_s1_next.valid = 1'b1;
        w_s1_next.mode  = approx_en;
        for (int k = 0; k < ROWS; k++) begin
            w_s1_next.t[k][WIDTH-1:0] = w_t[k];
            w_s1_next.b[k][WIDTH-2:0] = w_b[k];
            w_s1_next.m[k]            = y[WIDTH-1] & x[2*k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
        end else if (!w_stall) begin
            if (in_valid) r_s1 <= w_s1_next;
            else          r_s1.valid <= 1'b0;
        end
    end

    assign w_unused_s1 = ^{r_s1.mode, r_s1.t, r_s1.b, r_s1.m};

    always_comb begin
        w_sum_a = '0;
        w_sum_b = '0;
        for (int k = 0; k < ROWS; k++) begin
            w_sum_a = w_sum_a + (PW'(r_s1.t[k][WIDTH-1:0]) << (2 * k))
                              + (PW'(r_s1.m[k]) << (2 * k + WIDTH));
            w_sum_b = w_sum_b + (PW'(r_s1.b[k][WIDTH-2:0]) << (2 * k + 2));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_a2 <= '0;
            r_b2 <= '0;
        end else if (!w_stall) begin
            r_v2 <= r_s1.valid;
            if (r_s1.valid) begin
                r_a2 <= w_sum_a;
                r_b2 <= w_sum_b;
            end
        end
    end

    assign w_prod_next = r_a2 + r_b2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3   <= 1'b0;
            r_prod <= '0;
        end else if (!w_stall) begin
            r_v3 <= r_v2;
            if (r_v2) r_prod <= w_prod_next;
        end
    end

`ifdef APPROX_MUL_ERR_STAT_EN
    logic [WIDTH-1:0] r_x1;
    logic [WIDTH-1:0] r_y1;
    logic [WIDTH-1:0] r_x2;
    logic [WIDTH-1:0] r_y2;
    logic [PW-1:0]    w_exact;
    logic [PW-1:0]    r_err3;
    logic [15:0]      r_err_cnt;
    logic [PW-1:0]    r_err_max;

    assign w_exact = PW'(r_x2) * PW'(r_y2);
    assign err_cnt = r_err_cnt;
    assign err_max = r_err_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x1   <= '0;
            r_y1   <= '0;
            r_x2   <= '0;
            r_y2   <= '0;
            r_err3 <= '0;
        end else if (!w_stall) begin
            if (in_valid) begin
                r_x1 <= x;
                r_y1 <= y;
            end
            if (r_s1.valid) begin
                r_x2 <= r_x1;
                r_y2 <= r_y1;
            end
            // The approximation only ever drops weight, so this never wraps.
            if (r_v2) r_err3 <= w_exact - w_prod_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
            r_err_max <= '0;
        end else if (stat_clr) begin
            r_err_cnt <= '0;
            r_err_max <= '0;
        end else if (r_v3 && out_ready && (r_err3 != '0)) begin
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            if (r_err3 > r_err_max)    r_err_max <= r_err3;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/approx_mul_pipe.md
APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; even values 4..32 only.
REQ-002 SHALL have parameter APPROX_COLS, default 4: product bit-weights below this use OR-only cells; 0 gives an exact multiplier.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: input handshake.
REQ-006 SHALL have ports x input WIDTH, y input WIDTH: unsigned operands.
REQ-007 SHALL have port approx_en  input  1  per-transaction mode; 0 gives the exact product.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1: output handshake.
REQ-009 SHALL have port prod  output  2*WIDTH  result.

Function
REQ-010 SHALL accept a transaction on a clk edge with in_valid && in_ready, and deliver it on a clk edge with out_valid && out_ready.
REQ-011 SHALL partition x into WIDTH/2 pair-rows k: x[2k], x[2k+1].
- Row k cell j (1..WIDTH-1) combines y[j]&x[2k] with y[j-1]&x[2k+1].
- Cell weight w = 2k+j.
REQ-012 SHALL make a cell an OR cell, carry forced 0, when approx_en=1 and w < APPROX_COLS; every other cell is an exact half adder.
REQ-013 SHALL produce prod = x*y - sum(2^w) over OR cells whose both inputs are 1; with approx_en=0, prod = x*y exactly.
REQ-014 SHALL be a 3-stage pipeline with result latency exactly 3 cycles, without stall, from acceptance to out_valid:
- S1 registers the per-row t/b vectors.
- S2 registers the reduced two-operand sum.
- S3 registers the final prod.
REQ-015 SHALL sustain throughput of one transaction per cycle when out_ready=1.
REQ-016 SHALL stall all stages, holding every register, when out_valid && !out_ready; in_ready = !(out_valid && !out_ready).
REQ-017 SHALL keep prod stable while out_valid=1 and out_ready=0.
REQ-018 SHALL latch approx_en together with its operands, so mode changes never affect in-flight transactions.
REQ-019 SHALL allow acceptance and delivery on the same edge; occupancy is then unchanged.
REQ-020 SHALL ignore x, y and approx_en when not accepted.
REQ-021 SHALL pass bubbles (in_valid=0) through as invalid stages without altering valid data.

Reset
REQ-022 SHALL, on rst_n=0 asserted at any time, immediately clear all stage-valid flags, out_valid=0 and prod=0; in-flight transactions are discarded.
REQ-023 SHALL hold in_ready=1 during and after reset.
REQ-024 SHALL accept a transaction on the first edge after rst_n deasserts.

Configuration
REQ-025 SHALL support macro APPROX_MUL_ERR_STAT_EN.
- Defined: adds ports stat_clr input 1, err_cnt output 16, err_max output 2*WIDTH.
- S3 also computes exact x*y.
- Each delivered transaction with nonzero error increments err_cnt, saturating at 0xFFFF.
- err_max tracks the maximum |x*y - prod|.
- stat_clr=1 zeroes both, with priority over a same-cycle update.
- Reset zeroes both.
REQ-026 SHALL, with APPROX_MUL_ERR_STAT_EN undefined, omit those ports and the exact-product logic.

Structure
REQ-027 SHALL define in package approx_mul_pkg: the stage-count constant (3), the stage payload struct typedef (valid, mode, row vectors), and a loss function computing the REQ-013 error term.
REQ-028 SHALL instantiate one sub-module approx_mul_ha_row per pair-row: combinational, parameterised by WIDTH, APPROX_COLS and row index k, with outputs t[WIDTH] and b[WIDTH-1].

Verification
REQ-029 SHALL cover: WIDTH=8, APPROX_COLS=4, approx_en=1, x=0xFF, y=0xFF -> prod=65003 (0xFDEB) 3 cycles later; approx_en=0 -> 65025.
REQ-030 SHALL cover: x=3, y=3, approx_en=1 -> prod=7; x=2, y=3 -> prod=6 (no loss).
REQ-031 SHALL cover: 4 back-to-back transactions with out_ready=0 from cycle 3 for 5 cycles -> in_ready=0 after the pipeline fills, first prod held stable, all 4 delivered in order with no loss or duplication.
REQ-032 SHALL cover: rst_n pulsed low with 2 transactions in flight -> out_valid=0 and prod=0 immediately; neither transaction is delivered.
REQ-033 SHALL cover: APPROX_MUL_ERR_STAT_EN defined, sequence (0xFF,0xFF), (3,3), (2,3) -> err_cnt=2, err_max=22; stat_clr -> both 0.
REQ-034 SHALL cover: APPROX_COLS=0, exhaustive WIDTH=8 random-stall run -> prod == x*y for all 65536 pairs.
